// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: command and result handshake bundle for the ALU sequencer
interface alu_op_sequencer_if #(parameter int n = 32, parameter int CNT_W = 16);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic             cmd_acc;
  logic [n-1:0]     cmd_a;
  logic [n-1:0]     cmd_b;
  logic             res_valid;
  logic             res_ready;
  logic [n-1:0]     res_data;
  logic             res_zero;
  logic             res_carry;
  logic             res_ovf;
  logic [CNT_W-1:0] op_count;
  modport master (
    output cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, res_ready,
    input  cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf, op_count
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_acc, cmd_a, cmd_b, res_ready,
    output cmd_ready, res_valid, res_data, res_zero, res_carry, res_ovf, op_count
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts one ALU command at a time, evaluates it in one cycle
// and holds the result until consumed; operand A may chain from the last result.
module alu_op_sequencer #(parameter int n = 32, parameter int CNT_W = 16) (
  input logic               clk,
  input logic               rst,
  alu_op_sequencer_if.slave bus
);
  localparam int SW = $clog2(n);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t           r_state, w_next;
  logic [n-1:0]     r_a, r_b, r_data, w_res;
  logic [2:0]       r_op;
  logic             r_zero, r_carry, r_ovf, w_carry, w_ovf;
  logic [CNT_W-1:0] r_cnt;
  logic [n:0]       w_sum, w_diff;
  logic             w_accept, w_take;
  assign w_accept      = r_state == IDLE && bus.cmd_valid;
  assign w_take        = r_state == DONE && bus.res_ready;
  assign bus.cmd_ready = !rst && r_state == IDLE;
  assign bus.res_valid = !rst && r_state == DONE;
  assign bus.res_data  = r_data;
  assign bus.res_zero  = r_zero;
  assign bus.res_carry = r_carry;
  assign bus.res_ovf   = r_ovf;
  assign bus.op_count  = r_cnt;
  always_ff @(posedge clk)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_next = w_accept ? EXEC : r_state == EXEC ? DONE : w_take ? IDLE : r_state;
  end
  always_comb begin
    w_sum   = {1'b0, r_a} + {1'b0, r_b};
    w_diff  = {1'b0, r_a} - {1'b0, r_b};
    w_res   = '0;
    w_carry = 1'b0;
    w_ovf   = 1'b0;
    case (r_op)
      3'd0: begin
        w_res   = w_sum[n-1:0];
        w_carry = w_sum[n];
        w_ovf   = r_a[n-1] == r_b[n-1] && w_sum[n-1] != r_a[n-1];
      end
      3'd1: begin
        w_res   = w_diff[n-1:0];
        w_carry = ~w_diff[n];
        w_ovf   = r_a[n-1] != r_b[n-1] && w_diff[n-1] != r_a[n-1];
      end
      3'd2: w_res = r_a & r_b;
      3'd3: w_res = r_a | r_b;
      3'd4: w_res = r_a ^ r_b;
      3'd5: w_res = ~(r_a | r_b);
      3'd6: w_res = {{(n-1){1'b0}}, $signed(r_a) < $signed(r_b)};
      default: w_res = r_a << r_b[SW-1:0];
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_zero  <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_a  <= bus.cmd_acc ? r_data : bus.cmd_a;
        r_b  <= bus.cmd_b;
        r_op <= bus.cmd_op;
      end
      if (r_state == EXEC) begin
        r_data  <= w_res;
        r_zero  <= w_res == '0;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
      end
      if (w_take) r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and randomized checks against an arithmetic reference model
module tb_alu_op_sequencer;
  localparam int N = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic [N-1:0] m_res = '0;
  logic [15:0]  m_cnt = '0;
  alu_op_sequencer_if #(.n(N), .CNT_W(16)) bus ();
  alu_op_sequencer #(.n(N), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] r, output logic c, output logic v);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin
        r = a + b;
        c = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      3'd1: begin
        r = a - b;
        c = a >= b;
        s = sa - sb;
        v = s > 64'sd2147483647 || s < -64'sd2147483648;
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a | b);
      3'd6: r = (sa < sb) ? 1 : 0;
      default: r = a << b[4:0];
    endcase
  endfunction
  task automatic do_op(input logic [2:0] op, input logic acc, input logic [N-1:0] a,
                       input logic [N-1:0] b, input int stall);
    logic [N-1:0] ea, r;
    logic c, v;
    ea = acc ? m_res : a;
    model(op, ea, b, r, c, v);
    chk("idle_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_acc   = acc;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.res_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_acc   = 1'($urandom);
    bus.cmd_a     = $urandom;
    bus.cmd_b     = $urandom;
    chk("exec_ready", bus.cmd_ready, 0);
    chk("exec_valid", bus.res_valid, 0);
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk("done_valid", bus.res_valid, 1);
    chk("done_ready", bus.cmd_ready, 0);
    chk("res_data", bus.res_data, r);
    chk("res_zero", bus.res_zero, r == 0);
    chk("res_carry", bus.res_carry, c);
    chk("res_ovf", bus.res_ovf, v);
    chk("count_held", bus.op_count, m_cnt);
    for (int i = 0; i < stall; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'($urandom);
      bus.cmd_acc   = 1'($urandom);
      bus.cmd_a     = $urandom;
      bus.cmd_b     = $urandom;
      @(negedge clk);
      chk("stall_valid", bus.res_valid, 1);
      chk("stall_ready", bus.cmd_ready, 0);
      chk("stall_data", {bus.res_data, bus.res_zero, bus.res_carry, bus.res_ovf}, {r, r == 0, c, v});
      chk("stall_count", bus.op_count, m_cnt);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.cmd_valid = 1'b0;
    m_cnt++;
    m_res = r;
    chk("post_count", bus.op_count, m_cnt);
    chk("post_valid", bus.res_valid, 0);
    chk("post_ready", bus.cmd_ready, 1);
  endtask
  task automatic rst_mid(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_acc   = 1'b0;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.res_valid, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_flags", {bus.res_zero, bus.res_carry, bus.res_ovf}, 0);
    chk("rst_count", bus.op_count, 0);
    rst = 1'b0;
    m_res = '0;
    m_cnt = '0;
    @(negedge clk);
    chk("rst_idle", bus.cmd_ready, 1);
    chk("rst_idle_valid", bus.res_valid, 0);
  endtask
  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_acc   = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("reset_ready", bus.cmd_ready, 0);
    chk("reset_valid", bus.res_valid, 0);
    @(negedge clk);
    chk("reset_data", bus.res_data, 0);
    chk("reset_count", bus.op_count, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("release_ready", bus.cmd_ready, 1);
    do_op(3'd0, 1'b0, 32'h7FFF_FFFF, 32'd1, 0);
    do_op(3'd1, 1'b0, 32'd0, 32'd1, 0);
    do_op(3'd1, 1'b0, 32'd5, 32'd5, 0);
    do_op(3'd0, 1'b0, 32'd10, 32'd20, 0);
    do_op(3'd7, 1'b1, 32'h0000_DEAD, 32'h22, 0);
    chk("chain_120", bus.res_data, 32'd120);
    do_op(3'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
    do_op(3'd1, 1'b0, 32'h8000_0000, 32'd1, 0);
    do_op(3'd6, 1'b0, 32'hFFFF_FFFF, 32'd0, 0);
    chk("slt_one", bus.res_data, 32'd1);
    rst_mid(3'd0, 32'd3, 32'd4);
    do_op(3'd0, 1'b1, 32'h1234, 32'd7, 0);
    for (int k = 0; k < 60; k++) begin
      logic [N-1:0] a, b;
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 1) ? a : 32'hFFFF_FFFF;
      do_op(3'($urandom), 1'($urandom), a, b, int'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
